// File: rtl/debug_dump.sv
// -----------------------------------------------------------------------------
// debug_dump
//
// Walks the capture analyzer's buffer one sample at a time after a capture and
// streams each sample as uppercase ASCII hex over an 8N1 UART line.
//
// One line per sample:
//   word NUMWORDS-1 .. word 0 as HEXW hex chars each, words separated by 0x20,
//   terminated by 0x0D 0x0A.
//
// Ports
//   clk      in   sole clock
//   reset    in   asynchronous, active-high
//   start    in   rising edge begins a dump (ignored while busy)
//   abort    in   level; stops the dump at the next byte boundary
//   data_in  in   analyzer data_out, NUMWORDS*WORDLEN bits
//   next     out  one-cycle pulse advancing the analyzer read address
//   tx       out  UART 8N1, idle high
//   busy     out  high from the accepted start until back in IDLE
//   done     out  one-cycle pulse when a full dump completes
//
// Handshake with the analyzer: there is no valid/ready pair. A `next` pulse
// advances the analyzer address; data_in is trusted READ_WAIT cycles later,
// when the block latches it in LOAD.
// -----------------------------------------------------------------------------
module debug_dump #(
    parameter int WORDLEN      = 24,
    parameter int NUMWORDS     = 2,
    parameter int DEPTH        = 4096,
    parameter int READ_WAIT    = 4,
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUMWORDS*WORDLEN-1:0] data_in,
    output logic                        next,
    output logic                        tx,
    output logic                        busy,
    output logic                        done
);

    localparam int HEXW    = (WORDLEN + 3) / 4;
    localparam int HW_BITS = HEXW * 4;
    localparam int SH_W    = NUMWORDS * HW_BITS;
    localparam int CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_W  = $clog2(READ_WAIT);
    localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NIB_W   = $clog2(HEXW + 1);
    localparam int WORD_W  = $clog2(NUMWORDS + 1);

    localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(READ_WAIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [NIB_W-1:0]  NIB_SEP     = NIB_W'(HEXW);
    localparam logic [WORD_W-1:0] WORD_LF     = WORD_W'(NUMWORDS);
    localparam logic [WORD_W-1:0] WORD_LASTW  = WORD_W'(NUMWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_ADV  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic              start_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  sample_cnt;
    logic [SH_W-1:0]   shreg;
    logic [SH_W-1:0]   load_val;
    logic [NIB_W-1:0]  nib_cnt;     // 0..HEXW-1 hex chars, HEXW = separator slot
    logic [WORD_W-1:0] word_cnt;    // words already sent; NUMWORDS = LF slot
    logic [3:0]        bit_idx;     // 0 start, 1..8 data, 9 stop
    logic [BAUD_W-1:0] baud_cnt;
    logic              tx_q;
    logic [3:0]        nib;
    logic [7:0]        char_cur;
    logic              start_rise;
    logic              bit_last;
    logic              byte_end;
    logic              last_char;

    assign start_rise = start & ~start_q;
    assign bit_last   = (baud_cnt == BAUD_LAST);
    assign byte_end   = (state == S_SEND) && bit_last && (bit_idx == 4'd9);
    assign last_char  = (word_cnt == WORD_LF);

    // Each word is zero-extended to a whole number of nibbles so the top
    // nibble of the shift register is always the next hex digit to send.
    always_comb begin
        load_val = '0;
        for (int w = 0; w < NUMWORDS; w++) begin
            load_val[w*HW_BITS +: HW_BITS] = HW_BITS'(data_in[w*WORDLEN +: WORDLEN]);
        end
    end

    always_comb begin
        nib = shreg[SH_W-1 -: 4];
        if (word_cnt == WORD_LF) begin
            char_cur = 8'h0A;
        end else if (nib_cnt == NIB_SEP) begin
            char_cur = (word_cnt == WORD_LASTW) ? 8'h0D : 8'h20;
        end else if (nib < 4'd10) begin
            char_cur = 8'h30 + {4'h0, nib};
        end else begin
            char_cur = 8'h37 + {4'h0, nib};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. abort is only honoured at byte boundaries so a UART
    // frame is never cut short.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_rise) state_nxt = S_WAIT;
            S_WAIT: begin
                if (abort)                      state_nxt = S_IDLE;
                else if (wait_cnt == WAIT_LAST) state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = abort ? S_IDLE : S_SEND;
            S_SEND: begin
                if (byte_end) begin
                    if (abort)          state_nxt = S_IDLE;
                    else if (last_char) state_nxt = S_ADV;
                end
            end
            S_ADV: begin
                if (abort || (sample_cnt == LAST_SAMPLE)) state_nxt = S_IDLE;
                else                                      state_nxt = S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state != S_IDLE);
        next = (state == S_ADV) && !abort;
        done = next && (sample_cnt == LAST_SAMPLE);
        tx   = tx_q;
    end

    // Datapath: sample counter, read wait, character sequencer and UART TX.
    // tx_q is loaded with the value of the upcoming bit slot so the line is
    // registered and the start bit appears the cycle after LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q    <= 1'b0;
            wait_cnt   <= '0;
            sample_cnt <= '0;
            shreg      <= '0;
            nib_cnt    <= '0;
            word_cnt   <= '0;
            bit_idx    <= '0;
            baud_cnt   <= '0;
            tx_q       <= 1'b1;
        end else begin
            start_q <= start;

            if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            else                 wait_cnt <= '0;

            if (state == S_IDLE && state_nxt == S_WAIT) sample_cnt <= '0;
            else if (next)                              sample_cnt <= sample_cnt + 1'b1;

            if (state == S_LOAD && state_nxt == S_SEND) begin
                shreg    <= load_val;
                nib_cnt  <= '0;
                word_cnt <= '0;
                bit_idx  <= '0;
                baud_cnt <= '0;
                tx_q     <= 1'b0;
            end else if (state == S_SEND) begin
                if (!bit_last) begin
                    baud_cnt <= baud_cnt + 1'b1;
                end else begin
                    baud_cnt <= '0;
                    if (bit_idx != 4'd9) begin
                        bit_idx <= bit_idx + 4'd1;
                        tx_q    <= (bit_idx == 4'd8) ? 1'b1 : char_cur[bit_idx[2:0]];
                    end else if (state_nxt == S_SEND) begin
                        // Back-to-back byte: next start bit follows the stop bit
                        bit_idx <= '0;
                        tx_q    <= 1'b0;
                        if (nib_cnt == NIB_SEP) begin
                            nib_cnt  <= '0;
                            word_cnt <= word_cnt + 1'b1;
                        end else begin
                            nib_cnt <= nib_cnt + 1'b1;
                            shreg   <= shreg << 4;
                        end
                    end
                end
            end
        end
    end

endmodule
